// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module  : bcd_display_scanner
// Brief   : Multiplexed BCD scanner feeding a bcd_7448 with RBI leading-zero
//           suppression, blanking gaps and frame-aligned double buffering.
// Revision: 1.0
// ============================================================================
module bcd_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lz_en,
  input  logic                    lamp_test,
  output logic [3:0]              bcd,
  output logic                    LT,
  output logic                    BI,
  output logic                    RBI,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int                    c_TICK_W   = $clog2(SCAN_DIV);
  localparam int                    c_IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [c_TICK_W-1:0]   c_TICK_MAX = c_TICK_W'(SCAN_DIV - 1);
  localparam logic [c_TICK_W-1:0]   c_BLANK    = c_TICK_W'(BLANK_CYC);
  localparam logic [c_IDX_W-1:0]    c_IDX_MAX  = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_ONE      = NUM_DIGITS'(1);

  logic [c_TICK_W-1:0]     r_tick;
  logic [c_IDX_W-1:0]      r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_active;

  logic                    w_tick_wrap;
  logic                    w_boundary;
  logic                    w_show;
  logic [NUM_DIGITS:0]     w_upper_zero;
  logic [NUM_DIGITS-1:0]   w_digit_lz;

  assign w_tick_wrap = (r_tick == c_TICK_MAX);
  assign w_boundary  = w_tick_wrap && (r_idx == '0);
  assign w_show      = (r_tick >= c_BLANK);

  // w_upper_zero[k]: digits k..NUM_DIGITS-1 are all zero
  assign w_upper_zero[NUM_DIGITS] = 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
    assign w_upper_zero[g] = w_upper_zero[g+1] & (r_active[4*g +: 4] == 4'd0);
    if (g == 0) begin : g_units
      assign w_digit_lz[g] = 1'b0;
    end else begin : g_upper
      assign w_digit_lz[g] = w_upper_zero[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_idx  <= c_IDX_MAX;
    end else begin
      r_tick <= w_tick_wrap ? '0 : r_tick + c_TICK_W'(1);
      if (w_tick_wrap)
        r_idx <= (r_idx == '0) ? c_IDX_MAX : r_idx - c_IDX_W'(1);
    end
  end

  // The boundary transfer reads the pre-edge shadow, so a coincident load
  // stays pending for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      pending  <= 1'b0;
    end else begin
      if (w_boundary && pending)
        r_active <= r_shadow;
      if (load) begin
        r_shadow <= digits_in;
        pending  <= 1'b1;
      end else if (w_boundary) begin
        pending  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd         <= 4'd0;
      LT          <= 1'b1;
      BI          <= 1'b0;
      RBI         <= 1'b1;
      dig_en      <= '0;
      frame_start <= 1'b0;
    end else begin
      bcd         <= r_active[{r_idx, 2'b00} +: 4];
      LT          <= ~lamp_test;
      BI          <= w_show;
      RBI         <= ~(lz_en & w_digit_lz[r_idx]);
      dig_en      <= w_show ? (c_ONE << r_idx) : '0;
      frame_start <= (r_idx == c_IDX_MAX) && (r_tick == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_display_scanner
// Brief   : Self-checking bench against a frame-arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_bcd_display_scanner;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = N * SD;
  localparam logic [12:0] c_RST_VEC = {4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic        lz_en = 1'b0;
  logic        lamp_test = 1'b0;
  logic [3:0]  bcd;
  logic        LT, BI, RBI, frame_start, pending;
  logic [3:0]  dig_en;
  logic [12:0] obs;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          k;
  logic [15:0] m_shadow, m_active;
  logic        m_pending;
  logic [12:0] exp_vec;

  bcd_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .lz_en(lz_en), .lamp_test(lamp_test), .bcd(bcd), .LT(LT), .BI(BI),
    .RBI(RBI), .dig_en(dig_en), .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;
  assign obs = {bcd, LT, BI, RBI, dig_en, frame_start, pending};

  task automatic model_reset();
    k = 0; m_shadow = 16'h0; m_active = 16'h0; m_pending = 1'b0;
  endtask

  // One clock: predict from counters derived from k, advance the model, sample at posedge+1.
  task automatic cycle(input logic ld, input logic [15:0] din);
    int tk, id;
    logic [15:0] cur;
    logic show, rbi, np, bnd;
    logic [3:0] de;
    load = ld; digits_in = din;
    tk  = k % SD;
    id  = (N - 1) - ((k / SD) % N);
    cur = m_active >> (4 * id);
    show = (tk >= BC);
    rbi  = !(lz_en && id > 0 && cur == 16'h0);
    de   = show ? 4'(1 << id) : 4'h0;
    bnd  = ((k % FR) == FR - 1);
    np   = ld ? 1'b1 : (bnd ? 1'b0 : m_pending);
    if (bnd && m_pending) m_active = m_shadow;
    if (ld) m_shadow = din;
    m_pending = np;
    exp_vec = {cur[3:0], ~lamp_test, show, rbi, de, (id == N - 1 && tk == 0), np};
    k++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (obs !== c_RST_VEC) begin
      n_fail++; $display("FAIL reset got=%h exp=%h", obs, c_RST_VEC);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    lz_en = 1'b0; lamp_test = 1'b0;
    for (int i = 0; i < FR; i++) begin
      cycle(1'b0, 16'h0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL idle k=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
  endtask

  task automatic test_lz();
    logic [3:0] t_bcd [4];
    logic       t_rbi [4];
    int         fs_cnt;
    t_bcd = '{4'd5, 4'd0, 4'd3, 4'd0};
    t_rbi = '{1'b1, 1'b1, 1'b1, 1'b0};
    lz_en = 1'b1;
    cycle(1'b1, 16'h0305);
    while ((k % FR) != 0) begin
      cycle(1'b0, 16'h0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL lz_pre k=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
    fs_cnt = 0;
    for (int i = 0; i < FR; i++) begin
      cycle(1'b0, 16'h0);
      fs_cnt += int'(frame_start);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL lz k=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
      if ((i % SD) == 4) begin
        n_tests++;
        if (bcd !== t_bcd[3 - i / SD] || RBI !== t_rbi[3 - i / SD]) begin
          n_fail++;
          $display("FAIL lz_table digit=%0d got bcd=%0d rbi=%b exp bcd=%0d rbi=%b",
                   3 - i / SD, bcd, RBI, t_bcd[3 - i / SD], t_rbi[3 - i / SD]);
        end
      end
    end
    n_tests++;
    if (fs_cnt != 1) begin
      n_fail++; $display("FAIL frame_start_count got=%0d exp=1", fs_cnt);
    end
  endtask

  task automatic test_zero();
    cycle(1'b1, 16'h0000);
    for (int i = 0; i < 3 * FR; i++) begin
      lz_en = (i < 2 * FR);
      cycle(1'b0, 16'h0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL zero lz=%b k=%0d got=%h exp=%h", lz_en, k - 1, obs, exp_vec);
      end
    end
  endtask

  task automatic test_double_buffer();
    lz_en = 1'b0;
    while ((k % FR) != 10) cycle(1'b0, 16'h0);
    cycle(1'b1, 16'h1234);
    cycle(1'b0, 16'h0);
    cycle(1'b1, 16'h5678);
    n_tests++;
    if (pending !== 1'b1) begin
      n_fail++; $display("FAIL pending_set got=%b exp=1", pending);
    end
    for (int i = 0; i < 3 * FR; i++) begin
      // Mid-frame load, then a second load on the very boundary edge.
      if (i == 40)                        cycle(1'b1, 16'h9abc);
      else if ((k % FR) == FR - 1 && i > 40 && i < 40 + FR) cycle(1'b1, 16'h4321);
      else                                cycle(1'b0, 16'h0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL dbuf k=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
  endtask

  task automatic test_lamp();
    for (int i = 0; i < 2 * FR; i++) begin
      lamp_test = (i >= 4 && i < FR + 4);
      lz_en = 1'($urandom_range(0, 1));
      cycle(1'b0, 16'h0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL lamp k=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
    lamp_test = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int i = 0; i < 400; i++) begin
      lz_en     = 1'($urandom_range(0, 1));
      lamp_test = ($urandom_range(0, 9) == 0);
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = d & 16'h00ff;
      cycle(($urandom_range(0, 15) == 0), d);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL random k=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
    lamp_test = 1'b0;
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 16'h9876);
    while ((k % FR) != SD + 5) cycle(1'b0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== c_RST_VEC) begin
      n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, c_RST_VEC);
    end
    @(posedge clk); #1;
    n_tests++;
    if (obs !== c_RST_VEC) begin
      n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, c_RST_VEC);
    end
    rst_n = 1'b1;
    model_reset();
    lz_en = 1'b0;
    for (int i = 0; i < FR + 4; i++) begin
      cycle(1'b0, 16'h0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL post_reset k=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_lz();
    test_zero();
    test_double_buffer();
    test_lamp();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
